// File: rtl/if_redirect_ctrl.sv
// Fetch-side PC owner for the LC-3b pipeline: issues instruction reads, applies
// EX-stage redirects, squashes younger stages and drops wrong-path fetch data.
module if_redirect_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branch_enable,
  input  logic [15:0]      br_addr,
  input  logic [1:0]       pcmux_sel,
  input  logic             stall,
  input  logic             imem_resp,
  input  logic [15:0]      imem_rdata,
  output logic             imem_read,
  output logic [15:0]      imem_address,
  output logic             if_valid,
  output logic [15:0]      if_pc,
  output logic [15:0]      if_instr,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             redirect_err,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        pc_q, pc_d;
  logic [15:0]        pending_pc_q, pending_pc_d;
  logic [15:0]        buf_pc_q, buf_pc_d;
  logic [15:0]        buf_instr_q, buf_instr_d;
  logic               redirect_err_q, redirect_err_d;
  logic [CNT_W-1:0]   redirect_count_q, redirect_count_d;

  logic               redirect_acc;
  logic               redirect_bad;
  logic [15:0]        target;
  logic               read_raw;
  logic               valid_raw;

  always_comb begin
    redirect_acc = branch_enable && ((pcmux_sel == 2'b01) || (pcmux_sel == 2'b10));
    redirect_bad = branch_enable && ((pcmux_sel == 2'b00) || (pcmux_sel == 2'b11));
    target       = {br_addr[15:1], 1'b0};
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pending_pc_d     = pending_pc_q;
    buf_pc_d         = buf_pc_q;
    buf_instr_d      = buf_instr_q;
    redirect_err_d   = redirect_err_q | redirect_bad;
    redirect_count_d = redirect_count_q;
    read_raw         = 1'b0;
    valid_raw        = 1'b0;
    if_pc            = pc_q;
    if_instr         = imem_rdata;

    if (redirect_acc && !(&redirect_count_q)) begin
      redirect_count_d = redirect_count_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_FETCH: begin
        read_raw = 1'b1;
        if (redirect_acc) begin
          // A response landing with the redirect is wrong-path; nothing is left in flight.
          if (imem_resp) begin
            pc_d = target;
          end else begin
            pending_pc_d = target;
            state_d      = ST_DRAIN;
          end
        end else if (imem_resp) begin
          pc_d = pc_q + 16'd2;
          if (stall) begin
            buf_pc_d    = pc_q;
            buf_instr_d = imem_rdata;
            state_d     = ST_HOLD;
          end else begin
            valid_raw = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if_pc    = buf_pc_q;
        if_instr = buf_instr_q;
        if (redirect_acc) begin
          pc_d    = target;
          state_d = ST_FETCH;
        end else begin
          valid_raw = 1'b1;
          if (!stall) begin
            state_d = ST_FETCH;
          end
        end
      end

      ST_DRAIN: begin
        // Keep the original request stable until memory answers, then discard it.
        read_raw = 1'b1;
        if (imem_resp) begin
          pc_d    = redirect_acc ? target : pending_pc_q;
          state_d = ST_FETCH;
        end else if (redirect_acc) begin
          pending_pc_d = target;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_FETCH;
      pc_q             <= RESET_PC;
      pending_pc_q     <= RESET_PC;
      buf_pc_q         <= 16'h0000;
      buf_instr_q      <= 16'h0000;
      redirect_err_q   <= 1'b0;
      redirect_count_q <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      pending_pc_q     <= pending_pc_d;
      buf_pc_q         <= buf_pc_d;
      buf_instr_q      <= buf_instr_d;
      redirect_err_q   <= redirect_err_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  always_comb begin
    imem_read      = rst_n & read_raw;
    imem_address   = pc_q;
    if_valid       = rst_n & valid_raw;
    flush_if_id    = rst_n & redirect_acc;
    flush_id_ex    = rst_n & redirect_acc;
    redirect_err   = redirect_err_q;
    redirect_count = redirect_count_q;
  end

endmodule

// File: tb/tb_if_redirect_ctrl.sv
// Bench for if_redirect_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the fetch/redirect rules.
module tb_if_redirect_ctrl;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             branch_enable = 1'b0;
  logic [15:0]      br_addr = 16'h0000;
  logic [1:0]       pcmux_sel = 2'b00;
  logic             stall = 1'b0;
  logic             imem_resp = 1'b0;
  logic [15:0]      imem_rdata = 16'h0000;
  logic             imem_read;
  logic [15:0]      imem_address;
  logic             if_valid;
  logic [15:0]      if_pc;
  logic [15:0]      if_instr;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             redirect_err;
  logic [CNT_W-1:0] redirect_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_redirect_ctrl #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .branch_enable(branch_enable), .br_addr(br_addr),
    .pcmux_sel(pcmux_sel), .stall(stall), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .imem_read(imem_read), .imem_address(imem_address), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .redirect_err(redirect_err), .redirect_count(redirect_count)
  );

  // Reference model: the fetch unit is either issuing (with or without a stale
  // request to discard) or holding one buffered instruction.
  logic [15:0]      m_pc, m_pend, m_buf_pc, m_buf_instr;
  logic             m_hold, m_drain, m_err;
  logic [CNT_W-1:0] m_cnt;
  logic             m_redir, m_illegal;
  logic [15:0]      m_tgt;
  logic             exp_read, exp_valid;
  logic [15:0]      exp_pc, exp_instr;

  always_comb begin
    m_redir   = branch_enable && (pcmux_sel == 2'd1 || pcmux_sel == 2'd2);
    m_illegal = branch_enable && !(pcmux_sel == 2'd1 || pcmux_sel == 2'd2);
    m_tgt     = br_addr & 16'hFFFE;
    exp_read  = rst_n && !m_hold;
    exp_valid = 1'b0;
    exp_pc    = m_pc;
    exp_instr = imem_rdata;
    if (rst_n && m_hold) begin
      exp_valid = !m_redir;
      exp_pc    = m_buf_pc;
      exp_instr = m_buf_instr;
    end else if (rst_n && !m_drain) begin
      exp_valid = imem_resp && !m_redir && !stall;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RESET_PC; m_pend <= RESET_PC; m_hold <= 1'b0; m_drain <= 1'b0;
      m_buf_pc <= 16'h0; m_buf_instr <= 16'h0; m_err <= 1'b0; m_cnt <= '0;
    end else begin
      if (m_illegal) m_err <= 1'b1;
      if (m_redir) m_cnt <= (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1'b1;
      if (m_hold) begin
        if (m_redir) m_pc <= m_tgt;
        if (m_redir || !stall) m_hold <= 1'b0;
      end else if (m_drain) begin
        if (imem_resp) begin
          m_drain <= 1'b0;
          m_pc    <= m_redir ? m_tgt : m_pend;
        end else if (m_redir) begin
          m_pend <= m_tgt;
        end
      end else if (m_redir) begin
        if (imem_resp) m_pc <= m_tgt;
        else begin m_pend <= m_tgt; m_drain <= 1'b1; end
      end else if (imem_resp) begin
        m_pc <= m_pc + 16'd2;
        if (stall) begin
          m_hold <= 1'b1; m_buf_pc <= m_pc; m_buf_instr <= imem_rdata;
        end
      end
    end
  end

  task automatic set_in(input logic be, input logic [1:0] sel, input logic [15:0] addr,
                        input logic stl, input logic rsp, input logic [15:0] rd);
    @(negedge clk);
    branch_enable = be; pcmux_sel = sel; br_addr = addr;
    stall = stl; imem_resp = rsp; imem_rdata = rd;
    #1;
  endtask

  task automatic test_reset;
    set_in(1'b1, 2'b01, 16'h1234, 1'b0, 1'b1, 16'h0);
    n_cmp++;
    if ({imem_read, if_valid, flush_if_id, flush_id_ex} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 0000", {imem_read, if_valid, flush_if_id, flush_id_ex});
    end
    @(negedge clk);
    rst_n = 1'b1;
    branch_enable = 1'b0; pcmux_sel = 2'b00; imem_resp = 1'b0; stall = 1'b0;
    #1;
    n_cmp++;
    if ({imem_read, imem_address, if_valid, redirect_err, redirect_count} !== {1'b1, 16'h0000, 1'b0, 1'b0, {CNT_W{1'b0}}}) begin
      n_err++;
      $display("FAIL reset_state: got rd=%b addr=%h v=%b err=%b cnt=%0d expected rd=1 addr=0000 v=0 err=0 cnt=0",
               imem_read, imem_address, if_valid, redirect_err, redirect_count);
    end
  endtask

  task automatic test_basic_fetch;
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 16'h1234);
    n_cmp++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 16'h0000, 16'h1234}) begin
      n_err++;
      $display("FAIL first_fetch: got v=%b pc=%h instr=%h expected v=1 pc=0000 instr=1234", if_valid, if_pc, if_instr);
    end
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if ({imem_read, imem_address, if_valid} !== {1'b1, 16'h0002, 1'b0}) begin
      n_err++;
      $display("FAIL next_addr: got rd=%b addr=%h v=%b expected rd=1 addr=0002 v=0", imem_read, imem_address, if_valid);
    end
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 16'h5555);
    n_cmp++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 16'h0002, 16'h5555}) begin
      n_err++;
      $display("FAIL second_fetch: got v=%b pc=%h instr=%h expected v=1 pc=0002 instr=5555", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_redirect_drain;
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
    set_in(1'b1, 2'b01, 16'h0101, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if ({flush_if_id, flush_id_ex, imem_address, if_valid} !== {2'b11, 16'h0004, 1'b0}) begin
      n_err++;
      $display("FAIL redirect_flush: got fl=%b%b addr=%h v=%b expected fl=11 addr=0004 v=0", flush_if_id, flush_id_ex, imem_address, if_valid);
    end
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if ({flush_if_id, imem_read, imem_address} !== {1'b0, 1'b1, 16'h0004}) begin
      n_err++;
      $display("FAIL drain_hold_addr: got fl=%b rd=%b addr=%h expected fl=0 rd=1 addr=0004", flush_if_id, imem_read, imem_address);
    end
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 16'hDEAD);
    n_cmp++;
    if (if_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stale_resp: got v=%b expected v=0", if_valid);
    end
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if ({imem_read, imem_address, redirect_count} !== {1'b1, 16'h0100, CNT_W'(1)}) begin
      n_err++;
      $display("FAIL redirect_target: got rd=%b addr=%h cnt=%0d expected rd=1 addr=0100 cnt=1", imem_read, imem_address, redirect_count);
    end
  endtask

  task automatic test_stall_hold;
    set_in(1'b0, 2'b00, 16'h0, 1'b1, 1'b1, 16'hABCD);
    n_cmp++;
    if (if_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_capture: got v=%b expected v=0", if_valid);
    end
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 2'b00, 16'h0, 1'b1, 1'b0, 16'h0);
      n_cmp++;
      if ({imem_read, if_valid, if_pc, if_instr} !== {1'b0, 1'b1, 16'h0100, 16'hABCD}) begin
        n_err++;
        $display("FAIL hold_cycle%0d: got rd=%b v=%b pc=%h instr=%h expected rd=0 v=1 pc=0100 instr=abcd", i, imem_read, if_valid, if_pc, if_instr);
      end
    end
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if ({if_valid, if_pc} !== {1'b1, 16'h0100}) begin
      n_err++;
      $display("FAIL hold_release: got v=%b pc=%h expected v=1 pc=0100", if_valid, if_pc);
    end
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if ({imem_read, imem_address, if_valid} !== {1'b1, 16'h0102, 1'b0}) begin
      n_err++;
      $display("FAIL after_hold: got rd=%b addr=%h v=%b expected rd=1 addr=0102 v=0", imem_read, imem_address, if_valid);
    end
  endtask

  task automatic test_hold_redirect;
    set_in(1'b1, 2'b01, 16'h0010, 1'b0, 1'b1, 16'hBAD0);
    n_cmp++;
    if ({if_valid, flush_if_id} !== 2'b01) begin
      n_err++;
      $display("FAIL redirect_with_resp: got v=%b fl=%b expected v=0 fl=1", if_valid, flush_if_id);
    end
    set_in(1'b0, 2'b00, 16'h0, 1'b1, 1'b1, 16'h1111);
    set_in(1'b0, 2'b00, 16'h0, 1'b1, 1'b0, 16'h0);
    n_cmp++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 16'h0010, 16'h1111}) begin
      n_err++;
      $display("FAIL hold_at_0010: got v=%b pc=%h instr=%h expected v=1 pc=0010 instr=1111", if_valid, if_pc, if_instr);
    end
    set_in(1'b1, 2'b10, 16'h0201, 1'b1, 1'b0, 16'h0);
    n_cmp++;
    if ({flush_if_id, flush_id_ex, if_valid} !== 3'b110) begin
      n_err++;
      $display("FAIL hold_redirect: got fl=%b%b v=%b expected fl=11 v=0", flush_if_id, flush_id_ex, if_valid);
    end
    set_in(1'b0, 2'b00, 16'h0, 1'b1, 1'b0, 16'h0);
    n_cmp++;
    if ({imem_read, imem_address, if_valid, redirect_count} !== {1'b1, 16'h0200, 1'b0, CNT_W'(3)}) begin
      n_err++;
      $display("FAIL hold_redirect_target: got rd=%b addr=%h v=%b cnt=%0d expected rd=1 addr=0200 v=0 cnt=3", imem_read, imem_address, if_valid, redirect_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [CNT_W-1:0] c0;
    c0 = redirect_count;
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
    set_in(1'b1, 2'b01, 16'h0300, 1'b0, 1'b0, 16'h0);
    set_in(1'b1, 2'b10, 16'h0400, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if ({flush_if_id, imem_read, imem_address} !== {1'b1, 1'b1, 16'h0200}) begin
      n_err++;
      $display("FAIL second_redirect_drain: got fl=%b rd=%b addr=%h expected fl=1 rd=1 addr=0200", flush_if_id, imem_read, imem_address);
    end
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 16'hCAFE);
    n_cmp++;
    if (if_valid !== 1'b0) begin
      n_err++;
      $display("FAIL double_stale: got v=%b expected v=0", if_valid);
    end
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if ({imem_address, redirect_count} !== {16'h0400, c0 + CNT_W'(2)}) begin
      n_err++;
      $display("FAIL newest_target: got addr=%h cnt=%0d expected addr=0400 cnt=%0d", imem_address, redirect_count, c0 + CNT_W'(2));
    end
  endtask

  task automatic test_illegal_and_wrap;
    set_in(1'b1, 2'b00, 16'h0800, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if (flush_if_id !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_flush: got fl=%b expected fl=0", flush_if_id);
    end
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if ({imem_address, redirect_err} !== {16'h0400, 1'b1}) begin
      n_err++;
      $display("FAIL illegal_effect: got addr=%h err=%b expected addr=0400 err=1", imem_address, redirect_err);
    end
    set_in(1'b1, 2'b01, 16'hFFFF, 1'b0, 1'b1, 16'h0);
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 16'h7777);
    n_cmp++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 16'hFFFE, 16'h7777}) begin
      n_err++;
      $display("FAIL fetch_fffe: got v=%b pc=%h instr=%h expected v=1 pc=fffe instr=7777", if_valid, if_pc, if_instr);
    end
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if ({imem_address, redirect_err} !== {16'h0000, 1'b1}) begin
      n_err++;
      $display("FAIL pc_wrap: got addr=%h err=%b expected addr=0000 err=1", imem_address, redirect_err);
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      set_in(1'b1, 2'b01, 16'($urandom), 1'b0, 1'b1, 16'h0);
    end
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if (redirect_count !== CNT_MAX) begin
      n_err++;
      $display("FAIL counter_saturate: got %0d expected %0d", redirect_count, CNT_MAX);
    end
  endtask

  task automatic test_random;
    logic bad;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      branch_enable = ($urandom_range(0, 3) == 0);
      pcmux_sel     = 2'($urandom);
      br_addr       = 16'($urandom);
      stall         = ($urandom_range(0, 1) == 1);
      imem_resp     = exp_read && ($urandom_range(0, 2) == 0);
      imem_rdata    = 16'($urandom);
      #1;
      bad = (imem_read !== exp_read) || (exp_read && imem_address !== m_pc) ||
            (if_valid !== exp_valid) || (exp_valid && {if_pc, if_instr} !== {exp_pc, exp_instr}) ||
            (flush_if_id !== m_redir) || (flush_id_ex !== m_redir) ||
            (redirect_err !== m_err) || (redirect_count !== m_cnt);
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL random_cycle%0d: got rd=%b addr=%h v=%b pc=%h instr=%h fl=%b%b err=%b cnt=%0d expected rd=%b addr=%h v=%b pc=%h instr=%h fl=%b err=%b cnt=%0d",
                 i, imem_read, imem_address, if_valid, if_pc, if_instr, flush_if_id, flush_id_ex, redirect_err, redirect_count,
                 exp_read, m_pc, exp_valid, exp_pc, exp_instr, m_redir, m_err, m_cnt);
      end
    end
  endtask

  task automatic test_mid_reset;
    set_in(1'b1, 2'b01, 16'h0500, 1'b0, exp_read, 16'h0);
    set_in(1'b1, 2'b01, 16'h0A0A, 1'b0, 1'b0, 16'h0);
    set_in(1'b1, 2'b10, 16'h0C0C, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if ({imem_read, imem_address} !== {1'b1, 16'h0500}) begin
      n_err++;
      $display("FAIL pre_reset_drain: got rd=%b addr=%h expected rd=1 addr=0500", imem_read, imem_address);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({imem_read, if_valid, flush_if_id, flush_id_ex, redirect_count} !== {4'b0000, {CNT_W{1'b0}}}) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got rd=%b v=%b fl=%b%b cnt=%0d expected all 0", imem_read, if_valid, flush_if_id, flush_id_ex, redirect_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    branch_enable = 1'b0;
    #1;
    n_cmp++;
    if ({imem_read, imem_address, redirect_err} !== {1'b1, RESET_PC, 1'b0}) begin
      n_err++;
      $display("FAIL post_reset: got rd=%b addr=%h err=%b expected rd=1 addr=%h err=0", imem_read, imem_address, redirect_err, RESET_PC);
    end
    set_in(1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 16'h4242);
    n_cmp++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, RESET_PC, 16'h4242}) begin
      n_err++;
      $display("FAIL post_reset_fetch: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=4242", if_valid, if_pc, if_instr, RESET_PC);
    end
  endtask

  initial begin
    test_reset;
    test_basic_fetch;
    test_redirect_drain;
    test_stall_hold;
    test_hold_redirect;
    test_back_to_back;
    test_illegal_and_wrap;
    test_saturate;
    test_random;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
